// File: rtl/alu_div_pkg.sv
// Shared types and constants for the RV32IM divide/remainder sequencer.
//   div_op_e    : DIV / DIVU / REM / REMU encoding as carried on the op bus
//   div_state_e : sequencer FSM states
//   DATA_WIDTH, DIV_OVF_DIVIDEND, DIV_BY_ZERO_QUOTIENT : default-width constants
package alu_div_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ITER,
    ST_FIXUP,
    ST_DONE
  } div_state_e;

  // Most negative signed dividend; with a divisor of -1 its quotient would overflow.
  localparam logic [DATA_WIDTH-1:0] DIV_OVF_DIVIDEND     = 32'h8000_0000;
  // Quotient returned for a zero divisor.
  localparam logic [DATA_WIDTH-1:0] DIV_BY_ZERO_QUOTIENT = 32'hFFFF_FFFF;

  // DIV and REM treat their operands as two's-complement; op[0] marks the unsigned forms.
  function automatic logic is_signed_op(div_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/alu_div_if.sv
// Request/response bundle between the execute stage and the divide sequencer.
//   master : execute stage (drives flush, start, op, operand_A, operand_B, out_ready)
//   slave  : sequencer     (drives ready, busy, out_valid, result)
interface alu_div_if
  import alu_div_pkg::*;
#(
  parameter int unsigned data_width = DATA_WIDTH
);

  logic                  flush;
  logic                  start;
  div_op_e               op;
  logic [data_width-1:0] operand_A;
  logic [data_width-1:0] operand_B;
  logic                  ready;
  logic                  busy;
  logic                  out_valid;
  logic                  out_ready;
  logic [data_width-1:0] result;

  modport master (
    output flush, start, op, operand_A, operand_B, out_ready,
    input  ready, busy, out_valid, result
  );

  modport slave (
    input  flush, start, op, operand_A, operand_B, out_ready,
    output ready, busy, out_valid, result
  );

endinterface

// File: rtl/alu_div_step.sv
// One restoring-division iteration (purely combinational).
//   rem      : partial remainder, always below the divisor so data_width bits suffice
//   quo      : dividend bits still to be consumed / quotient bits produced so far
//   divisor  : divisor magnitude
//   rem_next : partial remainder after the trial subtraction (data_width+1 bits)
//   quo_next : quo shifted left with the new quotient bit in bit 0
module alu_div_step #(
  parameter int unsigned data_width = 32
) (
  input  logic [data_width-1:0] rem,
  input  logic [data_width-1:0] quo,
  input  logic [data_width-1:0] divisor,
  output logic [data_width:0]   rem_next,
  output logic [data_width-1:0] quo_next
);

  logic [data_width:0]   rem_shift;
  logic [data_width+1:0] diff;

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves it unassigned and no latch is inferred.
    rem_shift = {rem, quo[data_width-1]};
    diff      = {1'b0, rem_shift} - {2'b00, divisor};
    rem_next  = rem_shift;
    quo_next  = {quo[data_width-2:0], 1'b0};
    // The extra top bit of diff is the borrow: clear means the divisor fits.
    if (!diff[data_width+1]) begin
      rem_next = diff[data_width:0];
      quo_next = {quo[data_width-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/alu_div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU unit beside the single-cycle ALU.
//   clk : rising-edge clock
//   rst : synchronous active-high reset (wins over flush)
//   bus : alu_div_if slave -- start/ready accept, flush abort, busy stall,
//         out_valid/out_ready result return, result = quotient or remainder
// One operand bit is resolved per cycle with a restoring shift-subtract on
// magnitudes; signs are restored in FIXUP. Zero divisor and signed overflow
// are resolved in CHECK and skip the loop.
module alu_div_sequencer
  import alu_div_pkg::*;
#(
  parameter int unsigned data_width = DATA_WIDTH
) (
  input logic      clk,
  input logic      rst,
  alu_div_if.slave bus
);

  localparam int unsigned           cnt_width  = $clog2(data_width + 1);
  localparam logic [cnt_width-1:0]  last_iter  = cnt_width'(data_width - 1);
  localparam logic [data_width-1:0] min_signed = {1'b1, {(data_width-1){1'b0}}};
  localparam logic [data_width-1:0] all_ones   = '1;

  div_state_e            state_q, state_d;
  div_op_e               op_q;
  logic [data_width-1:0] a_q, b_q;
  logic [data_width-1:0] divisor_q;
  logic [data_width-1:0] quo_q;
  logic [data_width:0]   rem_q;
  logic [cnt_width-1:0]  cnt_q;
  logic                  neg_quo_q, neg_rem_q;

  logic                  signed_op, a_neg, b_neg;
  logic                  div_by_zero, overflow;
  logic [data_width:0]   step_rem;
  logic [data_width-1:0] step_quo;

  assign signed_op   = is_signed_op(op_q);
  assign a_neg       = signed_op & a_q[data_width-1];
  assign b_neg       = signed_op & b_q[data_width-1];
  assign div_by_zero = (b_q == '0);
  assign overflow    = signed_op && (a_q == min_signed) && (b_q == all_ones);

  alu_div_step #(.data_width(data_width)) u_step (
    .rem      (rem_q[data_width-1:0]),
    .quo      (quo_q),
    .divisor  (divisor_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  // NOTE: clocked state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.ready     = 1'b0;
    bus.busy      = 1'b0;
    bus.out_valid = 1'b0;
    bus.result    = '0;
    case (state_q)
      ST_IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        bus.busy = 1'b1;
        state_d  = (div_by_zero || overflow) ? ST_DONE : ST_ITER;
      end
      ST_ITER: begin
        bus.busy = 1'b1;
        if (cnt_q == last_iter) state_d = ST_FIXUP;
      end
      ST_FIXUP: begin
        bus.busy = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        bus.out_valid = 1'b1;
        bus.result    = op_q[1] ? rem_q[data_width-1:0] : quo_q;
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A pipeline kill overrides every transition, including an IDLE accept.
    if (bus.flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= OP_DIV;
      a_q       <= '0;
      b_q       <= '0;
      divisor_q <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (!bus.flush) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            op_q <= bus.op;
            a_q  <= bus.operand_A;
            b_q  <= bus.operand_B;
          end
        end
        ST_CHECK: begin
          cnt_q     <= '0;
          rem_q     <= '0;
          // Negating 0x8000_0000 yields 0x8000_0000, which is the correct
          // unsigned magnitude, so no extra bit is needed here.
          divisor_q <= b_neg ? -b_q : b_q;
          neg_quo_q <= a_neg ^ b_neg;
          neg_rem_q <= a_neg;
          if (div_by_zero) begin
            quo_q <= all_ones;
            rem_q <= {1'b0, a_q};
          end else if (overflow) begin
            quo_q <= min_signed;
          end else begin
            quo_q <= a_neg ? -a_q : a_q;
          end
        end
        ST_ITER: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          cnt_q <= cnt_q + 1'b1;
        end
        ST_FIXUP: begin
          if (neg_quo_q) quo_q <= -quo_q;
          if (neg_rem_q) rem_q <= -rem_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_sequencer.sv
// Self-checking bench for alu_div_sequencer: directed special cases, handshake,
// flush and reset behaviour, then random operands against a plain-arithmetic
// reference model.
module tb_alu_div_sequencer;
  import alu_div_pkg::*;

  localparam int NORMAL_EDGES  = 34; // valid cycle k+35: 34 edges after cycle k+1
  localparam int SPECIAL_EDGES = 1;  // valid cycle k+2

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;
  int   n_fail  = 0;

  alu_div_if #(.data_width(DATA_WIDTH)) bus ();

  alu_div_sequencer #(.data_width(DATA_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Truncating RISC-V division, computed with wide signed integers.
  function automatic logic [31:0] ref_result(div_op_e op, logic [31:0] a, logic [31:0] b);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) begin
      if (op == OP_DIV || op == OP_DIVU) return DIV_BY_ZERO_QUOTIENT;
      return a;
    end
    case (op)
      OP_DIV:  r = sa / sb;
      OP_REM:  r = sa % sb;
      OP_DIVU: r = longint'(a) / longint'(b);
      default: r = longint'(a) % longint'(b);
    endcase
    return r[31:0];
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"},     32'(bus.ready),     32'd1);
    check({tag, "_busy"},      32'(bus.busy),      32'd0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_result"},    bus.result,         32'd0);
  endtask

  // Returns at the negedge of cycle k+1 (the accept edge is k).
  task automatic issue(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    check("ready_before_start", 32'(bus.ready), 32'd1);
    bus.start     = 1'b1;
    bus.op        = op;
    bus.operand_A = a;
    bus.operand_B = b;
    @(negedge clk);
    bus.start     = 1'b0;
  endtask

  task automatic wait_valid(output int edges, output bit busy_ok);
    edges   = 0;
    busy_ok = 1'b1;
    while (bus.out_valid !== 1'b1 && edges < 100) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      edges++;
    end
    if (bus.busy !== 1'b0) busy_ok = 1'b0;
  endtask

  task automatic retire(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_ready_after_retire"}, 32'(bus.ready),     32'd1);
    check({tag, "_valid_after_retire"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic run_op(input string tag, input div_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_edges);
    int edges;
    bit busy_ok;
    issue(op, a, b);
    wait_valid(edges, busy_ok);
    check({tag, "_latency"}, 32'(edges), 32'(exp_edges));
    check({tag, "_busy"},    32'(busy_ok), 32'd1);
    check({tag, "_result"},  bus.result, exp);
    retire(tag);
  endtask

  initial begin
    int          edges;
    bit          busy_ok, seen_valid, stable;
    logic [31:0] held;
    div_op_e     op;
    logic [31:0] a, b;

    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.start     = 1'b0;
    bus.op        = OP_DIV;
    bus.operand_A = '0;
    bus.operand_B = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    // Directed arithmetic, including an out_ready held high before DONE.
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, NORMAL_EDGES);
    bus.out_ready = 1'b1;
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, NORMAL_EDGES);
    run_op("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, NORMAL_EDGES);
    run_op("rem_m7_2",   OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, NORMAL_EDGES);
    run_op("rem_7_m2",   OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, NORMAL_EDGES);
    run_op("div_5_0",    OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, SPECIAL_EDGES);
    run_op("rem_5_0",    OP_REM,  32'd5, 32'd0, 32'd5, SPECIAL_EDGES);
    run_op("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPECIAL_EDGES);
    run_op("rem_ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPECIAL_EDGES);
    run_op("divu_min_m1", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, NORMAL_EDGES);

    // Result held while out_ready is low; starts during DONE are ignored.
    issue(OP_DIVU, 32'd1000, 32'd3);
    wait_valid(edges, busy_ok);
    check("hold_result", bus.result, 32'd333);
    held   = bus.result;
    stable = 1'b1;
    bus.start     = 1'b1;
    bus.operand_A = 32'd77;
    bus.operand_B = 32'd5;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.result !== held) stable = 1'b0;
    end
    bus.start = 1'b0;
    check("hold_stable", 32'(stable), 32'd1);
    retire("hold");
    @(negedge clk);
    check("no_queued_start_ready", 32'(bus.ready), 32'd1);
    check("no_queued_start_busy",  32'(bus.busy),  32'd0);
    run_op("after_hold", OP_REMU, 32'd1000, 32'd3, 32'd1, NORMAL_EDGES);

    // Flush during ITER at cycle k+10.
    seen_valid = 1'b0;
    issue(OP_DIVU, 32'd1234, 32'd5);
    for (int i = 0; i < 9; i++) begin
      if (bus.out_valid === 1'b1) seen_valid = 1'b1;
      @(negedge clk);
    end
    check("busy_before_flush", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check_idle_outputs("after_flush");
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid === 1'b1) seen_valid = 1'b1;
      @(negedge clk);
    end
    check("flush_no_valid", 32'(seen_valid), 32'd0);

    // Reset during ITER at cycle k+20.
    issue(OP_DIV, 32'hFFFF_0000, 32'd3);
    repeat (19) @(negedge clk);
    check("busy_before_rst", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("after_rst");

    // start and flush together in IDLE: the start is dropped.
    @(negedge clk);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("start_flush_ready", 32'(bus.ready), 32'd1);
    check("start_flush_busy",  32'(bus.busy),  32'd0);
    run_op("after_start_flush", OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, NORMAL_EDGES);

    // Random operands against the reference model.
    for (int i = 0; i < 40; i++) begin
      op = div_op_e'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if (i % 4 == 1) b = $urandom_range(1, 15);
      if (i % 4 == 2) b = {28'hFFF_FFFF, 4'($urandom_range(0, 15))};
      if (i % 8 == 3) a = DIV_OVF_DIVIDEND;
      if (b == 32'd0) b = 32'd1;
      if (is_signed_op(op) && a == DIV_OVF_DIVIDEND && b == 32'hFFFF_FFFF) b = 32'd2;
      run_op($sformatf("rand%0d", i), op, a, b, ref_result(op, a, b), NORMAL_EDGES);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_div_sequencer.md
# alu_div_sequencer

Multi-cycle sequencer for the RV32IM divide/remainder instructions (DIV, DIVU, REM, REMU). It accepts one operation over a ready/start handshake, runs a restoring shift-subtract loop of one bit per cycle, and applies RISC-V sign and special-case rules. It returns the result over a valid/ready handshake. It sits beside the single-cycle ALU and stalls the execute stage while busy.

## Interface
- data_width, 32: operand and result width. Iteration count equals data_width.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  abort the current operation (pipeline kill)
- start  in  1  request; accepted when start && ready
- op  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- operand_A  in  data_width  dividend
- operand_B  in  data_width  divisor
- ready  out  1  high only in IDLE
- busy  out  1  high in CHECK, ITER, FIXUP
- out_valid  out  1  high in DONE
- out_ready  in  1  consumer accepts the result
- result  out  data_width  quotient (DIV/DIVU) or remainder (REM/REMU)

## Operation
- States: IDLE, CHECK, ITER, FIXUP, DONE.
- IDLE: on start && ready, latch op, operand_A and operand_B. Go to CHECK.
- CHECK: classify the operation. Load magnitudes (signed ops: two's-complement absolute value; unsigned ops: raw value). Record neg_q = sign(A) xor sign(B) and neg_r = sign(A), both for signed ops only. Clear the remainder register (data_width+1 bits) and the iteration counter.
  - Divisor == 0: quotient = all ones, remainder = operand_A. Go to DONE.
  - Signed op with A = 0x8000_0000 and B = 0xFFFF_FFFF: quotient = 0x8000_0000, remainder = 0. Go to DONE.
  - Otherwise go to ITER.
- ITER: each cycle, shift {rem, quo} left by 1. Trial-subtract the divisor from rem. If the difference is non-negative, rem = difference and quo[0] = 1. Otherwise rem is unchanged and quo[0] = 0. Increment the counter. After data_width iterations go to FIXUP.
- FIXUP: negate quo if neg_q; negate rem if neg_r. Go to DONE.
- DONE: present result selected by op[1]. Hold until out_ready, then go to IDLE.
- Arithmetic rules:
  - Signed results round toward zero.
  - The remainder takes the sign of the dividend.
  - abs(0x8000_0000) is handled as unsigned 0x8000_0000; no overflow.
- flush: from any state, go to IDLE next cycle. Clear out_valid and discard the in-flight result.
- rst has priority over flush. flush has priority over start.

## Timing
- Reset values:
  - state = IDLE, ready = 1, busy = 0, out_valid = 0, result = 0
  - internal counter, rem, quo and latched operands = 0
- Accept at edge k. CHECK occupies cycle k+1.
- Normal path: ITER occupies cycles k+2..k+33, FIXUP k+34. out_valid rises at k+35. Latency is 35 cycles from the accept edge to the valid cycle.
- Special-case path: out_valid rises at k+2.
- result is stable for the whole DONE period.
- out_ready && out_valid at edge m: ready = 1 in cycle m+1. The earliest next accept is edge m+1, so there is no back-to-back overlap.
- start while not ready: ignored; no queuing.
- out_ready while not in DONE: ignored.
- rst or flush asserted mid-ITER: the next cycle is IDLE with reset output values. No partial result is ever presented.
- start and flush in the same IDLE cycle: the start is dropped.

## Structure
- Package alu_div_pkg holds:
  - op enum typedef: DIV, DIVU, REM, REMU
  - state enum typedef
  - constants for the overflow dividend (0x8000_0000) and the all-ones quotient
- Sub-module alu_div_step: combinational single iteration. Inputs rem, quo, divisor; outputs next rem, next quo. Instantiated once inside ITER logic.
- FSM, counter and sign fixup live in alu_div_sequencer.

## Test plan
- DIVU 100 / 7 → result 14 at k+35. REMU 100 / 7 → result 2. busy high for k+1..k+34.
- DIV -7 / 2 → 0xFFFF_FFFD (-3). REM -7 / 2 → 0xFFFF_FFFF (-1). REM 7 / -2 → 1.
- DIV 5 / 0 → 0xFFFF_FFFF and REM 5 / 0 → 5, both valid at k+2. DIV 0x8000_0000 / -1 → 0x8000_0000; REM → 0.
- Hold out_ready = 0 for 10 cycles in DONE → out_valid and result stay constant. out_ready = 1 → ready next cycle. A new start is then accepted.
- flush at k+10 during ITER → IDLE at k+11, out_valid never asserted. rst at k+20 → all outputs at reset values next cycle.
- Random signed and unsigned operands, with B != 0 and the overflow pair excluded → result matches the reference model (truncating division) for all four ops.
